// File: rtl/life_rule_pipe.sv
// life_rule_pipe: 3x3 window birth/survive stage over a raster-scanned board.
// Emits next-generation cells, per-frame live totals and a generation count.
module life_rule_pipe #(
  parameter int X = 8,
  parameter int Y = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter logic [8:0] BIRTH = 9'b000001000,
  parameter logic [8:0] SURVIVE = 9'b000001100,
  parameter int GEN_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic sync_clr,
  input  logic tap_n,
  input  logic tap_c,
  input  logic tap_s,
  output logic pipe_out,
  output logic pipe_valid,
  output logic frame_done,
  output logic [LOG2X+LOG2Y:0] live_count,
  output logic [GEN_W-1:0] gen_count
);

  localparam int CW = LOG2X + LOG2Y + 1;
  localparam logic [LOG2X-1:0] XL = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] YL = LOG2Y'(Y - 1);
  localparam logic [15:0] B_TAB = {7'd0, BIRTH};
  localparam logic [15:0] S_TAB = {7'd0, SURVIVE};

  typedef struct packed {
    logic [LOG2Y-1:0] r;
    logic [LOG2X-1:0] c;
  } pos_t;

  pos_t tap_pos, tap_nxt;
  pos_t w_pos0, w_pos1, c_pos, r_pos;
  logic [2:0] w_n, w_c, w_s;
  logic [3:0] c_cnt, cnt;
  logic c_ctr;
  logic [3:0] vld;
  logic [CW-1:0] acc;
  logic [7:0] nb;
  logic m_w, m_e, m_n, m_s;
  logic out_last;

  always_comb begin
    tap_nxt = tap_pos;
    if (tap_pos.c == XL) begin
      tap_nxt.c = '0;
      tap_nxt.r = (tap_pos.r == YL) ? '0 : tap_pos.r + 1'b1;
    end else begin
      tap_nxt.c = tap_pos.c + 1'b1;
    end
  end

  // Off-board neighbours read as dead; row wrap in the window is masked too.
  always_comb begin
    m_w = w_pos1.c != '0;
    m_e = w_pos1.c != XL;
    m_n = w_pos1.r != '0;
    m_s = w_pos1.r != YL;
    nb = {w_n[2] & m_n & m_w, w_n[1] & m_n, w_n[0] & m_n & m_e,
          w_c[2] & m_w, w_c[0] & m_e,
          w_s[2] & m_s & m_w, w_s[1] & m_s, w_s[0] & m_s & m_e};
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, nb[i]};
  end

  assign out_last = (r_pos.c == XL) && (r_pos.r == YL);
  assign pipe_valid = vld[3];
  assign frame_done = shift_en & ~sync_clr & vld[3] & out_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_pos <= '0;
      w_pos0 <= '0;
      w_pos1 <= '0;
      c_pos <= '0;
      r_pos <= '0;
      w_n <= '0;
      w_c <= '0;
      w_s <= '0;
      c_cnt <= '0;
      c_ctr <= 1'b0;
      pipe_out <= 1'b0;
      vld <= '0;
      acc <= '0;
      live_count <= '0;
      gen_count <= '0;
    end else if (sync_clr) begin
      tap_pos <= '0;
      w_pos0 <= '0;
      w_pos1 <= '0;
      w_n <= '0;
      w_c <= '0;
      w_s <= '0;
      vld <= '0;
      acc <= '0;
    end else if (shift_en) begin
      tap_pos <= tap_nxt;
      w_pos0 <= tap_pos;
      w_pos1 <= w_pos0;
      w_n <= {w_n[1:0], tap_n};
      w_c <= {w_c[1:0], tap_c};
      w_s <= {w_s[1:0], tap_s};
      c_cnt <= cnt;
      c_ctr <= w_c[1];
      c_pos <= w_pos1;
      pipe_out <= c_ctr ? S_TAB[c_cnt] : B_TAB[c_cnt];
      r_pos <= c_pos;
      vld <= {vld[2:0], 1'b1};
      if (vld[3]) begin
        if (out_last) begin
          live_count <= acc + CW'(pipe_out);
          acc <= '0;
          gen_count <= gen_count + 1'b1;
        end else begin
          acc <= acc + CW'(pipe_out);
        end
      end
    end
  end

endmodule

// File: tb/tb_life_rule_pipe.sv
// tb_life_rule_pipe: directed boards against a generation-level Life model.
// Two instances: default B3/S23, and B6/S23 with a 2-bit generation count.
`timescale 1ns/1ps
module tb_life_rule_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic shift_en = 1'b0;
  logic sync_clr = 1'b0;
  logic tap_n = 1'b0;
  logic tap_c = 1'b0;
  logic tap_s = 1'b0;
  logic po0, pv0, fd0, po1, pv1, fd1;
  logic [6:0] lc0, lc1;
  logic [15:0] gc0;
  logic [1:0] gc1;
  int checks = 0;
  int failures = 0;

  life_rule_pipe dut0 (
    .clk(clk), .reset(reset), .shift_en(shift_en), .sync_clr(sync_clr),
    .tap_n(tap_n), .tap_c(tap_c), .tap_s(tap_s),
    .pipe_out(po0), .pipe_valid(pv0), .frame_done(fd0),
    .live_count(lc0), .gen_count(gc0)
  );

  life_rule_pipe #(.GEN_W(2), .BIRTH(9'b001000000)) dut1 (
    .clk(clk), .reset(reset), .shift_en(shift_en), .sync_clr(sync_clr),
    .tap_n(tap_n), .tap_c(tap_c), .tap_s(tap_s),
    .pipe_out(po1), .pipe_valid(pv1), .frame_done(fd1),
    .live_count(lc1), .gen_count(gc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit e0;
    bit e1;
  } cell_t;

  cell_t q[$];
  int pos = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Conway-style rule on an 8x8 board with dead surroundings.
  function automatic bit next_cell(bit [63:0] b, int x, int y, bit b6);
    int n = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        int xx = x + dx;
        int yy = y + dy;
        if ((dx != 0 || dy != 0) && xx >= 0 && xx < 8 && yy >= 0 && yy < 8)
          n += int'(b[yy*8+xx]);
      end
    end
    if (b[y*8+x]) return (n == 2 || n == 3);
    return b6 ? (n == 6) : (n == 3);
  endfunction

  task automatic step(bit en, bit clr, bit n, bit c, bit s);
    @(posedge clk);
    #1;
    shift_en = en;
    sync_clr = clr;
    tap_n = n;
    tap_c = c;
    tap_s = s;
  endtask

  task automatic feed(bit [63:0] b, int ncell, int stall_pct);
    cell_t e;
    int x, y, st;
    for (int k = 0; k < ncell; k++) begin
      st = 0;
      while (st < 5 && $urandom_range(99) < stall_pct) begin
        step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        st++;
      end
      x = pos % 8;
      y = pos / 8;
      step(1'b1, 1'b0, b[((y+7)%8)*8+x], b[y*8+x], b[((y+1)%8)*8+x]);
      e.idx = pos;
      e.e0 = next_cell(b, x, y, 1'b0);
      e.e1 = next_cell(b, x, y, 1'b1);
      q.push_back(e);
      pos = (pos + 1) % 64;
    end
  endtask

  task automatic restart();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pos = 0;
  endtask

  int since = 0;
  bit last_adv = 0, last_hold = 0, last_clr = 0, cur_last = 0;
  bit will_adv, exp_fd, log_gen = 0;
  int fsum0 = 0, fsum1 = 0, m_live0 = 0, m_live1 = 0, m_gen = 0;
  logic prev_po0, prev_po1, prev_pv0, prev_pv1;
  bit [63:0] cap0 = '0, cap1 = '0, frame0 = '0, frame1 = '0;
  int fd_since[$];
  int gen1_log[$];
  cell_t e;

  always @(negedge clk) begin
    will_adv = shift_en & ~sync_clr & reset;
    if (!reset) begin
      since = 0;
      q.delete();
      fsum0 = 0;
      fsum1 = 0;
      m_live0 = 0;
      m_live1 = 0;
      m_gen = 0;
      cur_last = 0;
      log_gen = 0;
    end else if (last_clr) begin
      since = 0;
      cur_last = 0;
    end else if (last_adv) begin
      since++;
      if (since >= 4) begin
        if (q.size() == 0) begin
          chk("queue_underrun", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("pipe_out0", po0, e.e0);
          chk("pipe_out1", po1, e.e1);
          fsum0 += int'(e.e0);
          fsum1 += int'(e.e1);
          cap0[e.idx] = po0;
          cap1[e.idx] = po1;
          cur_last = (e.idx == 63);
        end
      end
    end
    if (log_gen && reset) begin
      gen1_log.push_back(int'(gc1));
      log_gen = 0;
    end
    if (reset && last_hold) begin
      chk("hold_out0", po0, prev_po0);
      chk("hold_out1", po1, prev_po1);
      chk("hold_valid0", pv0, prev_pv0);
    end
    chk("valid0", pv0, since >= 4);
    chk("valid1", pv1, since >= 4);
    chk("live0", lc0, m_live0);
    chk("live1", lc1, m_live1);
    chk("gen0", gc0, m_gen % 65536);
    chk("gen1", gc1, m_gen % 4);
    exp_fd = will_adv && since >= 4 && cur_last;
    chk("frame_done0", fd0, exp_fd);
    chk("frame_done1", fd1, exp_fd);
    if (exp_fd) begin
      m_live0 = fsum0;
      m_live1 = fsum1;
      fsum0 = 0;
      fsum1 = 0;
      m_gen++;
      frame0 = cap0;
      frame1 = cap1;
      fd_since.push_back(since);
      log_gen = 1;
      cur_last = 0;
    end
    if (sync_clr && reset) begin
      q.delete();
      fsum0 = 0;
      fsum1 = 0;
    end
    last_adv = will_adv;
    last_clr = sync_clr & reset;
    last_hold = ~shift_en & ~sync_clr & reset;
    prev_po0 = po0;
    prev_po1 = po1;
    prev_pv0 = pv0;
    prev_pv1 = pv1;
  end

  initial begin
    bit [63:0] blink, blink_nx, block, singles, lone;
    blink = '0;
    blink[26] = 1'b1;
    blink[27] = 1'b1;
    blink[28] = 1'b1;
    blink_nx = '0;
    blink_nx[19] = 1'b1;
    blink_nx[27] = 1'b1;
    blink_nx[35] = 1'b1;
    block = '0;
    block[0] = 1'b1;
    block[1] = 1'b1;
    block[8] = 1'b1;
    block[9] = 1'b1;
    singles = '0;
    singles[31] = 1'b1;
    singles[32] = 1'b1;
    lone = '0;
    lone[27] = 1'b1;

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_out", po0, 1'b0);
    chk("rst_valid", pv0, 1'b0);
    chk("rst_done", fd0, 1'b0);
    chk("rst_live", lc0, 7'd0);
    chk("rst_gen", gc0, 16'd0);

    fd_since.delete();
    feed(blink, 64, 0);
    feed('0, 4, 0);
    restart();
    chk("blink_fd_adv", fd_since.size() > 0 ? fd_since[0] : -1, 67);
    chk("blink_frame", frame0, blink_nx);
    chk("blink_live", lc0, 7'd3);
    chk("blink_gen", gc0, 16'd1);
    chk("blink_b6_live", lc1, 7'd1);
    chk("blink_b6_frame", frame1, lone);

    feed(block, 64, 0);
    feed('0, 4, 0);
    restart();
    chk("block_frame", frame0, block);
    chk("block_live", lc0, 7'd4);

    feed(singles, 64, 0);
    feed('0, 4, 0);
    restart();
    chk("edge_frame", frame0, 64'd0);
    chk("edge_live", lc0, 7'd0);
    chk("edge_gen", gc0, 16'd3);

    feed(blink, 64, 50);
    feed('0, 4, 50);
    restart();
    chk("stall_frame", frame0, blink_nx);
    chk("stall_live", lc0, 7'd3);

    feed(blink, 20, 0);
    restart();
    chk("clr_gen", gc0, 16'd4);
    chk("clr_live", lc0, 7'd3);
    fd_since.delete();
    feed(blink, 64, 0);
    feed('0, 4, 0);
    restart();
    chk("clr_fd_adv", fd_since.size() > 0 ? fd_since[0] : -1, 67);
    chk("clr_gen_after", gc0, 16'd5);

    feed(blink, 30, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    shift_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    pos = 0;
    gen1_log.delete();
    feed(blink, 320, 0);
    feed(lone, 64, 0);
    feed('0, 4, 0);
    restart();
    chk("gen_log_len", gen1_log.size(), 6);
    if (gen1_log.size() >= 5) begin
      chk("gen_seq0", gen1_log[0], 1);
      chk("gen_seq1", gen1_log[1], 2);
      chk("gen_seq2", gen1_log[2], 3);
      chk("gen_seq3", gen1_log[3], 0);
      chk("gen_seq4", gen1_log[4], 1);
    end
    chk("b6_dies_live", lc1, 7'd0);
    chk("lone_dies_live", lc0, 7'd0);
    chk("reset_gen_total", gc0, 16'd6);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
